boss_attack_scheduler: RTL and testbench

BOSS_ATTACK_SCHEDULER -- requirements
Module: boss_attack_scheduler

---
 rtl/boss_pkg.sv | 34 +++
 rtl/slot_allocator.sv | 59 +++++
 rtl/boss_attack_scheduler.sv | 175 +++++++++++++++++
 tb/tb_boss_attack_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boss_pkg.sv
// -----------------------------------------------------------------------------
// boss_pkg
// Shared definitions for the boss attack scheduler: the phase encoding, the
// default hit thresholds and shot periods, the number of bullet slots and the
// launch offset below the boss top edge.
// -----------------------------------------------------------------------------
package boss_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PHASE1   = 3'd1,
        PHASE2   = 3'd2,
        PHASE3   = 3'd3,
        DEFEATED = 3'd4
    } phase_t;

    localparam logic [8:0] DEF_HIT_MAX  = 9'd200;
    localparam logic [8:0] DEF_PH2_HITS = 9'd100;
    localparam logic [8:0] DEF_PH3_HITS = 9'd160;

    localparam logic [5:0] DEF_PERIOD1  = 6'd60;
    localparam logic [5:0] DEF_PERIOD2  = 6'd30;
    localparam logic [5:0] DEF_PERIOD3  = 6'd15;

    localparam int         DEF_N_SLOTS  = 4;

    localparam logic [9:0] FIRE_Y_OFFSET = 10'd30;

    // Launch height: boss top edge plus offset, wrapping in 10 bits.
    function automatic logic [9:0] launch_y(input logic [9:0] boss_y);
        return boss_y + FIRE_Y_OFFSET;
    endfunction

endpackage

// File: rtl/slot_allocator.sv
// -----------------------------------------------------------------------------
// slot_allocator
// Keeps one busy flag per boss-bullet slot and grants the lowest-index free
// slot when a shot is requested. The grant is decided from the busy vector as
// it stood before this cycle's update, so a slot freed by i_done this cycle
// cannot be handed out until the next one.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous active-high reset (clears every busy flag)
//   i_req          shot request for this cycle
//   i_done         per-slot release pulse; ignored for slots already free
//   o_grant_valid  request accepted this cycle (combinational)
//   o_grant_idx    slot index being granted (meaningful with o_grant_valid)
//   o_busy         registered occupancy flags
// -----------------------------------------------------------------------------
module slot_allocator
    import boss_pkg::*;
#(
    parameter int N_SLOTS = DEF_N_SLOTS
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req,
    input  logic [N_SLOTS-1:0] i_done,
    output logic               o_grant_valid,
    output logic [1:0]         o_grant_idx,
    output logic [N_SLOTS-1:0] o_busy
);

    localparam logic [N_SLOTS-1:0] ONE = {{(N_SLOTS-1){1'b0}}, 1'b1};

    logic [N_SLOTS-1:0] r_busy;
    logic [N_SLOTS-1:0] w_free;
    logic [N_SLOTS-1:0] w_lowest;

    // Lowest-free priority encoder: x & -x isolates the lowest set free bit.
    always_comb begin
        w_free        = ~r_busy;
        w_lowest      = w_free & (~w_free + ONE);
        o_grant_valid = i_req & (|w_free);
        o_grant_idx   = 2'd0;
        for (int k = 0; k < N_SLOTS; k++) begin
            o_grant_idx = o_grant_idx | (w_lowest[k] ? 2'(k) : 2'd0);
        end
    end

    // Busy register: releases first, then the granted slot is marked taken.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~i_done) | (o_grant_valid ? w_lowest : '0);
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/boss_attack_scheduler.sv
// -----------------------------------------------------------------------------
// boss_attack_scheduler
// Boss-fight shot scheduler. A frame tick recovered from frame_clk drives a
// per-phase period counter; each expiry requests one bullet, which is placed
// in the lowest free sprite slot. Phases advance with the boss hit count and
// the fight ends in DEFEATED until Reset or key_R.
//
// Ports
//   Clk            system clock
//   Reset, key_R   synchronous active-high restart (either one)
//   frame_clk      asynchronous ~60 Hz frame level
//   state_index    game state, 2 = boss fight
//   boss_counter   boss hit count
//   boss_Y_Pos     boss top edge Y
//   slot_done      per-slot release pulses
//   fire_valid     one-cycle launch pulse
//   fire_slot      launched slot index (with fire_valid)
//   fire_Y         launch Y (with fire_valid)
//   slot_busy      slot occupancy
//   phase          current phase encoding
//   boss_defeated  high in DEFEATED
// -----------------------------------------------------------------------------
module boss_attack_scheduler
    import boss_pkg::*;
#(
    parameter logic [8:0] HIT_MAX  = DEF_HIT_MAX,
    parameter logic [8:0] PH2_HITS = DEF_PH2_HITS,
    parameter logic [8:0] PH3_HITS = DEF_PH3_HITS,
    parameter logic [5:0] PERIOD1  = DEF_PERIOD1,
    parameter logic [5:0] PERIOD2  = DEF_PERIOD2,
    parameter logic [5:0] PERIOD3  = DEF_PERIOD3,
    parameter int         N_SLOTS  = DEF_N_SLOTS
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               key_R,
    input  logic [3:0]         state_index,
    input  logic [8:0]         boss_counter,
    input  logic [9:0]         boss_Y_Pos,
    input  logic [N_SLOTS-1:0] slot_done,
    output logic               fire_valid,
    output logic [1:0]         fire_slot,
    output logic [9:0]         fire_Y,
    output logic [N_SLOTS-1:0] slot_busy,
    output logic [2:0]         phase,
    output logic               boss_defeated
);

    logic       w_rst;
    logic       r_sync0;
    logic       r_sync1;
    logic       w_tick;
    phase_t     r_phase;
    phase_t     w_phase_next;
    logic [5:0] r_cnt;
    logic       w_in_phase;
    logic       w_stay;
    logic       w_entry;
    logic       w_shot_req;
    logic       w_grant_valid;
    logic [1:0] w_grant_idx;
    logic       r_fire_valid;
    logic [1:0] r_fire_slot;
    logic [9:0] r_fire_y;
    logic       r_defeated;

    assign w_rst = Reset | key_R;

    function automatic logic [5:0] period_of(input phase_t p);
        case (p)
            PHASE2:  return PERIOD2;
            PHASE3:  return PERIOD3;
            default: return PERIOD1;
        endcase
    endfunction

    // Two-flop sampler for the asynchronous frame level.
    always_ff @(posedge Clk) begin
        if (w_rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= frame_clk;
            r_sync1 <= r_sync0;
        end
    end

    assign w_tick = r_sync0 & ~r_sync1;

    // Next-phase logic: leaving the fight beats defeat, defeat beats advancing.
    always_comb begin
        w_phase_next = r_phase;
        case (r_phase)
            IDLE: begin
                if (state_index == 4'd2) w_phase_next = PHASE1;
                else                     w_phase_next = IDLE;
            end
            PHASE1, PHASE2, PHASE3: begin
                if (state_index != 4'd2)                           w_phase_next = IDLE;
                else if (boss_counter >= HIT_MAX)                  w_phase_next = DEFEATED;
                else if (r_phase == PHASE1 && boss_counter >= PH2_HITS) w_phase_next = PHASE2;
                else if (r_phase == PHASE2 && boss_counter >= PH3_HITS) w_phase_next = PHASE3;
                else                                               w_phase_next = r_phase;
            end
            DEFEATED: w_phase_next = DEFEATED;
            default:  w_phase_next = IDLE;
        endcase
    end

    assign w_in_phase = (r_phase == PHASE1) || (r_phase == PHASE2) || (r_phase == PHASE3);
    assign w_stay     = (w_phase_next == r_phase);
    assign w_entry    = !w_stay && ((w_phase_next == PHASE1) ||
                                    (w_phase_next == PHASE2) ||
                                    (w_phase_next == PHASE3));
    // A tick that coincides with a phase change only restarts the count.
    assign w_shot_req = w_tick && w_in_phase && w_stay && (r_cnt == 6'd1);

    // Phase register and defeated flag.
    always_ff @(posedge Clk) begin
        if (w_rst) begin
            r_phase    <= IDLE;
            r_defeated <= 1'b0;
        end else begin
            r_phase    <= w_phase_next;
            r_defeated <= (w_phase_next == DEFEATED);
        end
    end

    // Period counter: reload on phase entry and on expiry, count down per tick.
    always_ff @(posedge Clk) begin
        if (w_rst) begin
            r_cnt <= PERIOD1;
        end else if (w_entry) begin
            r_cnt <= period_of(w_phase_next);
        end else if (w_tick && w_in_phase && w_stay) begin
            if (r_cnt == 6'd1) r_cnt <= period_of(r_phase);
            else               r_cnt <= r_cnt - 6'd1;
        end
    end

    slot_allocator #(
        .N_SLOTS (N_SLOTS)
    ) u_slot_allocator (
        .i_clk         (Clk),
        .i_rst         (w_rst),
        .i_req         (w_shot_req),
        .i_done        (slot_done),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx),
        .o_busy        (slot_busy)
    );

    // Launch registers; slot and Y hold their last value between shots.
    always_ff @(posedge Clk) begin
        if (w_rst) begin
            r_fire_valid <= 1'b0;
            r_fire_slot  <= 2'd0;
            r_fire_y     <= 10'd0;
        end else begin
            r_fire_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_fire_slot <= w_grant_idx;
                r_fire_y    <= launch_y(boss_Y_Pos);
            end
        end
    end

    assign fire_valid    = r_fire_valid;
    assign fire_slot     = r_fire_slot;
    assign fire_Y        = r_fire_y;
    assign phase         = r_phase;
    assign boss_defeated = r_defeated;

endmodule

// File: tb/tb_boss_attack_scheduler.sv
module tb_boss_attack_scheduler;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       key_R;
    logic [3:0] state_index;
    logic [8:0] boss_counter;
    logic [9:0] boss_Y_Pos;
    logic [3:0] slot_done;
    logic       fire_valid;
    logic [1:0] fire_slot;
    logic [9:0] fire_Y;
    logic [3:0] slot_busy;
    logic [2:0] phase;
    logic       boss_defeated;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int       m_phase  = 0;
    int       m_frames = 0;
    bit [3:0] m_busy   = 4'b0;
    bit       h1 = 1'b0;
    bit       h2 = 1'b0;
    bit       exp_valid;
    int       exp_slot;
    int       exp_y;
    bit       chk_data;

    typedef struct {
        logic [3:0] sidx;
        logic [8:0] hits;
        logic [2:0] exp_phase;
        logic       exp_def;
    } phase_vec_t;

    typedef struct {
        logic [9:0] y;
        logic [9:0] exp_y;
    } y_vec_t;

    boss_attack_scheduler dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .key_R         (key_R),
        .state_index   (state_index),
        .boss_counter  (boss_counter),
        .boss_Y_Pos    (boss_Y_Pos),
        .slot_done     (slot_done),
        .fire_valid    (fire_valid),
        .fire_slot     (fire_slot),
        .fire_Y        (fire_Y),
        .slot_busy     (slot_busy),
        .phase         (phase),
        .boss_defeated (boss_defeated)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int period(input int p);
        case (p)
            1:       return 60;
            2:       return 30;
            default: return 15;
        endcase
    endfunction

    function automatic int next_phase(input int p, input int sidx, input int hits);
        case (p)
            0:       return (sidx == 2) ? 1 : 0;
            4:       return 4;
            default: begin
                if (sidx != 2)                return 0;
                if (hits >= 200)              return 4;
                if (p == 1 && hits >= 100)    return 2;
                if (p == 2 && hits >= 160)    return 3;
                return p;
            end
        endcase
    endfunction

    // One clock: advance the model from the current inputs, then compare.
    task automatic step();
        bit tick;
        int nxt;
        int free;
        bit shot;
        tick = h1 && !h2;
        shot = 1'b0;
        exp_valid = 1'b0;
        chk_data = 1'b0;
        if (Reset || key_R) begin
            m_phase = 0; m_frames = 0; m_busy = 4'b0; h1 = 1'b0; h2 = 1'b0;
            exp_slot = 0; exp_y = 0; chk_data = 1'b1;
        end else begin
            nxt = next_phase(m_phase, int'(state_index), int'(boss_counter));
            if (nxt != m_phase) begin
                m_frames = 0;
            end else if (tick && m_phase >= 1 && m_phase <= 3) begin
                m_frames++;
                if (m_frames == period(m_phase)) begin
                    shot = 1'b1;
                    m_frames = 0;
                end
            end
            free = -1;
            for (int k = 3; k >= 0; k--) if (!m_busy[k]) free = k;
            m_busy = m_busy & ~slot_done;
            if (shot && free >= 0) begin
                m_busy[free] = 1'b1;
                exp_valid = 1'b1;
                exp_slot = free;
                exp_y = (int'(boss_Y_Pos) + 30) % 1024;
                chk_data = 1'b1;
            end
            m_phase = nxt;
            h2 = h1;
            h1 = frame_clk;
        end
        @(posedge Clk);
        #1;
        chk("fire_valid", fire_valid, exp_valid);
        chk("slot_busy", slot_busy, m_busy);
        chk("phase", phase, m_phase);
        chk("boss_defeated", boss_defeated, m_phase == 4);
        if (chk_data) begin
            chk("fire_slot", fire_slot, exp_slot);
            chk("fire_Y", fire_Y, exp_y);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    // One frame: 2 cycles high, 2 low; done mask lands in the tick cycle.
    task automatic tick(input logic [3:0] done, output bit fired, output int slot, output int y);
        frame_clk = 1'b1;
        step();
        slot_done = done;
        step();
        slot_done = 4'b0;
        fired = fire_valid;
        slot = fire_slot;
        y = fire_Y;
        frame_clk = 1'b0;
        step();
        step();
    endtask

    task automatic wait_fire(input int max_ticks, output int n, output int slot, output int y);
        bit f;
        int s;
        int yy;
        n = 0; slot = -1; y = -1;
        for (int i = 1; i <= max_ticks; i++) begin
            tick(4'b0, f, s, yy);
            if (f) begin
                n = i; slot = s; y = yy;
                break;
            end
        end
    endtask

    task automatic quiet(input int nt, output int nf);
        bit f;
        int s;
        int y;
        nf = 0;
        for (int i = 0; i < nt; i++) begin
            tick(4'b0, f, s, y);
            if (f) nf++;
        end
    endtask

    initial begin
        phase_vec_t pv[11];
        y_vec_t     yv[5];
        int n, s, y, nf;
        int fire_t[$];
        int fire_s[$];
        int fire_y[$];
        bit f;

        pv[0]  = '{4'd0, 9'd0,   3'd0, 1'b0};
        pv[1]  = '{4'd2, 9'd0,   3'd1, 1'b0};
        pv[2]  = '{4'd2, 9'd99,  3'd1, 1'b0};
        pv[3]  = '{4'd2, 9'd100, 3'd2, 1'b0};
        pv[4]  = '{4'd2, 9'd159, 3'd2, 1'b0};
        pv[5]  = '{4'd2, 9'd160, 3'd3, 1'b0};
        pv[6]  = '{4'd2, 9'd199, 3'd3, 1'b0};
        pv[7]  = '{4'd2, 9'd200, 3'd4, 1'b1};
        pv[8]  = '{4'd2, 9'd511, 3'd4, 1'b1};
        pv[9]  = '{4'd1, 9'd200, 3'd0, 1'b0};
        pv[10] = '{4'd3, 9'd0,   3'd0, 1'b0};

        yv[0] = '{10'd0,    10'd30};
        yv[1] = '{10'd1000, 10'd6};
        yv[2] = '{10'd993,  10'd1023};
        yv[3] = '{10'd994,  10'd0};
        yv[4] = '{10'd500,  10'd530};

        Reset = 1'b1; key_R = 1'b0; frame_clk = 1'b0; state_index = 4'd0;
        boss_counter = 9'd0; boss_Y_Pos = 10'd100; slot_done = 4'b0;
        cyc(2);
        chk("rst_phase", phase, 3'd0);
        chk("rst_fire_valid", fire_valid, 1'b0);
        chk("rst_slot_busy", slot_busy, 4'b0);
        chk("rst_fire_slot", fire_slot, 2'd0);
        chk("rst_fire_Y", fire_Y, 10'd0);
        chk("rst_defeated", boss_defeated, 1'b0);
        Reset = 1'b0;

        // Phase selection from a fresh start
        foreach (pv[i]) begin
            do_reset();
            state_index = pv[i].sidx;
            boss_counter = pv[i].hits;
            cyc(4);
            chk($sformatf("tbl_phase_%0d", i), phase, pv[i].exp_phase);
            chk($sformatf("tbl_defeated_%0d", i), boss_defeated, pv[i].exp_def);
        end

        // Phase 1: shots at ticks 60 and 120
        do_reset();
        state_index = 4'd2; boss_counter = 9'd0; boss_Y_Pos = 10'd100;
        cyc(2);
        for (int t = 1; t <= 121; t++) begin
            tick(4'b0, f, s, y);
            if (f) begin
                fire_t.push_back(t); fire_s.push_back(s); fire_y.push_back(y);
            end
        end
        chk("p1_fire_count", fire_t.size(), 2);
        if (fire_t.size() == 2) begin
            chk("p1_first_tick", fire_t[0], 60);
            chk("p1_second_tick", fire_t[1], 120);
            chk("p1_first_slot", fire_s[0], 0);
            chk("p1_second_slot", fire_s[1], 1);
            chk("p1_fire_Y", fire_y[0], 130);
        end

        // All slots busy: drop, then a released slot is reused
        boss_counter = 9'd160;
        cyc(3);
        chk("full_phase3", phase, 3'd3);
        wait_fire(20, n, s, y);
        chk("full_tick_a", n, 15);
        chk("full_slot_a", s, 2);
        wait_fire(20, n, s, y);
        chk("full_tick_b", n, 15);
        chk("full_slot_b", s, 3);
        quiet(15, nf);
        chk("full_drop", nf, 0);
        chk("full_busy", slot_busy, 4'hF);
        slot_done = 4'b0100;
        step();
        slot_done = 4'b0;
        wait_fire(20, n, s, y);
        chk("full_refire_tick", n, 15);
        chk("full_refire_slot", s, 2);

        // Release coincident with a request
        do_reset();
        state_index = 4'd2; boss_counter = 9'd160;
        cyc(4);
        wait_fire(20, n, s, y);
        wait_fire(20, n, s, y);
        chk("coin_setup_slot", s, 1);
        quiet(14, nf);
        tick(4'b0010, f, s, y);
        chk("coin_fired", f, 1'b1);
        chk("coin_slot", s, 2);
        chk("coin_busy", slot_busy, 4'b0101);

        // Reset in the request cycle
        quiet(14, nf);
        frame_clk = 1'b1;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rst_shot_valid", fire_valid, 1'b0);
        chk("rst_shot_phase", phase, 3'd0);
        chk("rst_shot_busy", slot_busy, 4'b0);
        chk("rst_shot_slot", fire_slot, 2'd0);
        chk("rst_shot_Y", fire_Y, 10'd0);
        frame_clk = 1'b0;
        cyc(2);

        // Hit count walks through the phases
        do_reset();
        state_index = 4'd2; boss_counter = 9'd99;
        cyc(2);
        chk("walk_p1", phase, 3'd1);
        boss_counter = 9'd100;
        cyc(2);
        chk("walk_p2", phase, 3'd2);
        wait_fire(40, n, s, y);
        chk("walk_spacing_p2", n, 30);
        boss_counter = 9'd160;
        cyc(2);
        chk("walk_p3", phase, 3'd3);
        slot_done = 4'hF;
        step();
        slot_done = 4'b0;
        wait_fire(20, n, s, y);
        chk("walk_spacing_p3", n, 15);
        boss_counter = 9'd200;
        cyc(2);
        chk("walk_defeated_phase", phase, 3'd4);
        chk("walk_defeated_flag", boss_defeated, 1'b1);
        quiet(20, nf);
        chk("walk_defeated_quiet", nf, 0);
        chk("walk_defeated_hold", phase, 3'd4);
        key_R = 1'b1;
        step();
        key_R = 1'b0;
        chk("keyr_phase", phase, 3'd0);
        chk("keyr_busy", slot_busy, 4'b0);
        chk("keyr_defeated", boss_defeated, 1'b0);
        state_index = 4'd0;
        boss_counter = 9'd0;
        cyc(2);

        // Launch height wrap-around, then leaving the fight
        do_reset();
        state_index = 4'd2; boss_counter = 9'd160;
        cyc(4);
        foreach (yv[i]) begin
            boss_Y_Pos = yv[i].y;
            slot_done = 4'hF;
            step();
            slot_done = 4'b0;
            wait_fire(20, n, s, y);
            chk($sformatf("wrap_Y_%0d", i), y, yv[i].exp_y);
        end
        state_index = 4'd1;
        cyc(2);
        chk("leave_idle", phase, 3'd0);
        quiet(20, nf);
        chk("leave_quiet", nf, 0);

        // Randomized run against the model
        do_reset();
        state_index = 4'd2; boss_counter = 9'd0;
        for (int c = 0; c < 8000; c++) begin
            frame_clk = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0)
                state_index = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
            if ($urandom_range(0, 63) == 0)
                boss_counter = boss_counter + 9'($urandom_range(0, 12));
            slot_done = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            boss_Y_Pos = 10'($urandom);
            key_R = ($urandom_range(0, 1499) == 0);
            Reset = ($urandom_range(0, 1999) == 0);
            if (key_R || Reset) boss_counter = 9'd0;
            step();
        end
        key_R = 1'b0;
        Reset = 1'b0;
        slot_done = 4'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
